sensor_filtro: RTL and testbench
================================

SENSOR_FILTRO -- requirements
Module: sensor_filtro

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles required before a clean output changes (range 1..15).
REQ-002 Parameter STUCK_CYCLES, default 255: consecutive cycles a critical sensor may stay 1 before a fault is raised (range 1..1023).
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Raw input ports, each 1 bit: RF_raw (final straight), TM_raw (hot engine), SC_raw (curve), E_raw (enable), AM_raw (manual accelerator), DM_raw (manual decelerator).
REQ-006 Port SP_raw, input, 2: raw car-position sensor vector.
REQ-007 Clean output ports, each 1 bit: RF, TM, SC, E, AM, DM (filtered, registered).
REQ-008 Port SP, output, 2: filtered position vector.
REQ-009 Port CHG, output, 1: one-cycle pulse when any clean output changes.
REQ-010 Port FLT, output, 1: sticky stuck-sensor fault.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before filtering.
REQ-012 Each channel SHALL run a 2-state FSM:
  - STABLE -> COUNT when the synced value differs from the clean output.
  - COUNT -> STABLE with counter cleared when the synced value equals the clean output again.
  - COUNT -> STABLE with the clean output updated when the counter reaches DB_CYCLES.
REQ-013 SP SHALL be filtered as one 2-bit channel; any change of the synced vector during COUNT SHALL restart the count; intermediate codes held fewer than DB_CYCLES cycles SHALL never appear on SP.
REQ-014 Latency from a raw change to the clean output SHALL be exactly 2+DB_CYCLES cycles for a glitch-free input.
REQ-015 A raw pulse shorter than DB_CYCLES synced cycles SHALL produce no output change and no CHG.
REQ-016 CHG SHALL assert in the same cycle the clean output updates, for exactly one cycle; simultaneous updates on several channels SHALL give a single pulse.
REQ-017 Debounce counters SHALL saturate at DB_CYCLES and SHALL never wrap.
REQ-018 With AM=1 and DM=1 simultaneously, both SHALL be passed through unchanged; arbitration belongs to the downstream race-mode/gearbox FSMs.

Reset
REQ-019 While rst=1, the following SHALL be 0: all synchronizer flops, counters, clean outputs, SP=00, CHG and FLT; every FSM SHALL be in STABLE.
REQ-020 rst asserted mid-count SHALL discard the partial count; filtering SHALL restart from zero on the first cycle after rst deasserts.

Configuration
REQ-021 Macro SENSOR_STUCK_DETECT_EN:
  - Defined: a counter SHALL increment each cycle that clean TM=1 or SC=1 and clear otherwise. When it reaches STUCK_CYCLES, FLT SHALL be set to 1, held until rst, and force output E=0, returning control to the manual pedals.
  - Undefined: FLT SHALL be tied 0, no stuck counter SHALL exist, and E SHALL follow its filtered value.

Structure
REQ-022 Package sensor_pkg SHALL hold the DB_CYCLES and STUCK_CYCLES defaults, the channel-state enum (STABLE, COUNT) and counter-width constants.
REQ-023 One sub-module, debounce_canal (parameterized width, synchronizer + FSM + counter), SHALL be instantiated once per channel; CHG OR-reduction and stuck logic stay in the top level.

Verification
REQ-024 rst=1 for 2 cycles with all raw inputs 1 -> all outputs 0, CHG=0; after release, all clean outputs reach 1 exactly 6 cycles later with one CHG pulse.
REQ-025 TM_raw 0->1 held -> TM=1 exactly 6 cycles later (DB_CYCLES=4); CHG high for that single cycle.
REQ-026 AM_raw high for 3 cycles then low -> AM stays 0, CHG never pulses.
REQ-027 SP_raw 00->01 for 2 cycles, then 10 held -> SP goes 00->10 six cycles after the 10 edge; 01 never observed.
REQ-028 Macro defined, STUCK_CYCLES=255, E_raw=1, TM_raw held 300 cycles -> FLT=1 and E=0 at cycle 2+4+255; TM_raw released -> FLT stays 1 until rst.
REQ-029 AM_raw high 3 cycles then rst pulse for 1 cycle while AM_raw stays high -> AM=0 during reset, AM=1 exactly 6 cycles after rst deasserts.

Source files
------------

// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor_filtro block:
//   - default debounce / stuck-fault cycle counts
//   - per-channel filter FSM state encoding
//   - counter widths sized for the full legal parameter ranges
//   - bit positions of the six single-bit channels inside the packed raw vector
// -----------------------------------------------------------------------------
package sensor_pkg;

    // Default parameter values for the top level.
    localparam int DB_CYCLES_DEF    = 4;    // legal range 1..15
    localparam int STUCK_CYCLES_DEF = 255;  // legal range 1..1023

    // Widths wide enough for the maximum legal parameter values.
    localparam int DB_CNT_W    = 4;         // holds up to 15
    localparam int STUCK_CNT_W = 10;        // holds up to 1023

    // Per-channel debounce FSM.
    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } chan_state_t;

    // Positions of the single-bit channels in the packed vector used by the top.
    localparam int CH_DM    = 0;
    localparam int CH_AM    = 1;
    localparam int CH_E     = 2;
    localparam int CH_SC    = 3;
    localparam int CH_TM    = 4;
    localparam int CH_RF    = 5;
    localparam int N_BIT_CH = 6;

endpackage : sensor_pkg

// File: rtl/debounce_canal.sv
// -----------------------------------------------------------------------------
// debounce_canal
// One filtered sensor channel of configurable width: a 2-flop synchronizer
// followed by a STABLE/COUNT debounce FSM with a saturating counter.
// The clean output only changes after the synchronized value has held the
// same new code for DB_CYCLES consecutive cycles, giving a raw-to-clean
// latency of 2 + DB_CYCLES cycles for a glitch-free input.
//
// Parameters:
//   WIDTH     - channel width in bits (1 for switches, 2 for the position code)
//   DB_CYCLES - stable cycles required before the clean output changes (1..15)
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   i_raw   - asynchronous raw sensor value
//   o_clean - registered, debounced value
//   o_upd   - registered one-cycle strobe, high in the cycle o_clean changed
// -----------------------------------------------------------------------------
module debounce_canal
    import sensor_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_clean,
    output logic             o_upd
);

    localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);
    localparam logic [DB_CNT_W-1:0] CNT_SAT  = DB_CNT_W'(DB_CYCLES);
    // Count value from which the next stable cycle completes the debounce.
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0]    r_sync1;
    logic [WIDTH-1:0]    r_sync2;
    logic [WIDTH-1:0]    r_clean;
    logic [WIDTH-1:0]    r_cand;    // code currently being qualified
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_upd;
    chan_state_t         r_state;

    // NOTE: every register here is state, so it is assigned only with <=;
    // blocking assignments in a clocked block create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_clean <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_upd   <= 1'b0;
            r_state <= STABLE;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_upd   <= 1'b0;

            case (r_state)
                STABLE: begin
                    r_cnt <= '0;
                    if (r_sync2 != r_clean) begin
                        if (DB_CYCLES == 1) begin
                            // A single stable cycle already satisfies the filter.
                            r_clean <= r_sync2;
                            r_upd   <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                            r_cand  <= r_sync2;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end

                COUNT: begin
                    if (r_sync2 == r_clean) begin
                        // Input fell back: discard the partial count.
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_sync2 != r_cand) begin
                        // A different new code (multi-bit only): qualify it from scratch
                        // so intermediate codes can never reach the output.
                        r_cand <= r_sync2;
                        r_cnt  <= CNT_ONE;
                    end else if (r_cnt >= CNT_LAST) begin
                        r_clean <= r_cand;
                        r_upd   <= 1'b1;
                        r_cnt   <= CNT_SAT;   // saturate; cleared again in STABLE
                        r_state <= STABLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_clean = r_clean;
    assign o_upd   = r_upd;

endmodule : debounce_canal

// File: rtl/sensor_filtro.sv
// -----------------------------------------------------------------------------
// sensor_filtro
// Debounce front end for the race-car sensors. Six single-bit channels and the
// 2-bit position code are each filtered by a debounce_canal instance. The top
// level merges the per-channel update strobes into a single CHG pulse and,
// optionally, watches the critical sensors for a stuck-at-1 condition.
//
// Optional feature (macro SENSOR_STUCK_DETECT_EN):
//   defined   - a counter runs while clean TM or SC is 1; reaching STUCK_CYCLES
//               sets the sticky FLT, which forces E to 0 until rst.
//   undefined - FLT is tied 0 and E is the plain filtered value.
//
// Parameters:
//   DB_CYCLES    - debounce length in cycles (1..15)
//   STUCK_CYCLES - stuck-sensor threshold in cycles (1..1023)
//
// Ports:
//   clk, rst                                   - clock, synchronous active-high reset
//   RF_raw, TM_raw, SC_raw, E_raw, AM_raw, DM_raw, SP_raw[1:0] - raw sensor inputs
//   RF, TM, SC, E, AM, DM, SP[1:0]             - filtered outputs
//   CHG                                        - one-cycle pulse on any output change
//   FLT                                        - sticky stuck-sensor fault
// -----------------------------------------------------------------------------
module sensor_filtro
    import sensor_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RF_raw,
    input  logic       TM_raw,
    input  logic       SC_raw,
    input  logic       E_raw,
    input  logic       AM_raw,
    input  logic       DM_raw,
    input  logic [1:0] SP_raw,
    output logic       RF,
    output logic       TM,
    output logic       SC,
    output logic       E,
    output logic       AM,
    output logic       DM,
    output logic [1:0] SP,
    output logic       CHG,
    output logic       FLT
);

    logic [N_BIT_CH-1:0] w_raw;
    logic [N_BIT_CH-1:0] w_clean;
    logic [N_BIT_CH-1:0] w_upd;
    logic [1:0]          w_sp_clean;
    logic                w_sp_upd;
    logic                w_flt;
    logic                w_flt_pulse;

    always_comb begin
        w_raw         = '0;
        w_raw[CH_RF]  = RF_raw;
        w_raw[CH_TM]  = TM_raw;
        w_raw[CH_SC]  = SC_raw;
        w_raw[CH_E]   = E_raw;
        w_raw[CH_AM]  = AM_raw;
        w_raw[CH_DM]  = DM_raw;
    end

    // Single-bit channels.
    genvar g;
    generate
        for (g = 0; g < N_BIT_CH; g++) begin : g_bit_ch
            debounce_canal #(
                .WIDTH     (1),
                .DB_CYCLES (DB_CYCLES)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[g]),
                .o_clean (w_clean[g]),
                .o_upd   (w_upd[g])
            );
        end
    endgenerate

    // Position code is filtered as one 2-bit word so both bits switch together.
    debounce_canal #(
        .WIDTH     (2),
        .DB_CYCLES (DB_CYCLES)
    ) u_sp (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (SP_raw),
        .o_clean (w_sp_clean),
        .o_upd   (w_sp_upd)
    );

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [STUCK_CNT_W-1:0] STUCK_ONE = STUCK_CNT_W'(1);
    localparam logic [STUCK_CNT_W-1:0] STUCK_MAX = STUCK_CNT_W'(STUCK_CYCLES);
    localparam logic [STUCK_CNT_W-1:0] STUCK_HIT = STUCK_CNT_W'(STUCK_CYCLES - 1);

    logic [STUCK_CNT_W-1:0] r_stuck_cnt;
    logic                   r_flt;
    logic                   r_flt_pulse;
    logic                   w_critical;
    logic                   w_stuck_hit;

    assign w_critical  = w_clean[CH_TM] | w_clean[CH_SC];
    // True on the edge at which the counter reaches STUCK_CYCLES.
    assign w_stuck_hit = w_critical && (r_stuck_cnt == STUCK_HIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stuck_cnt <= '0;
            r_flt       <= 1'b0;
            r_flt_pulse <= 1'b0;
        end else begin
            if (!w_critical) begin
                r_stuck_cnt <= '0;
            end else if (r_stuck_cnt != STUCK_MAX) begin
                r_stuck_cnt <= r_stuck_cnt + STUCK_ONE;
            end

            if (w_stuck_hit) begin
                r_flt <= 1'b1;
            end

            // Forcing E low is itself an output change when E was showing 1.
            r_flt_pulse <= w_stuck_hit & ~r_flt & w_clean[CH_E];
        end
    end

    assign w_flt       = r_flt;
    assign w_flt_pulse = r_flt_pulse;
`else
    assign w_flt       = 1'b0;
    assign w_flt_pulse = 1'b0;
`endif

    assign RF  = w_clean[CH_RF];
    assign TM  = w_clean[CH_TM];
    assign SC  = w_clean[CH_SC];
    assign E   = w_clean[CH_E] & ~w_flt;
    assign AM  = w_clean[CH_AM];   // AM and DM pass through even when both are 1
    assign DM  = w_clean[CH_DM];
    assign SP  = w_sp_clean;
    assign FLT = w_flt;

    // An E update hidden behind an active fault does not change the output.
    assign CHG = w_upd[CH_RF] | w_upd[CH_TM] | w_upd[CH_SC] | w_upd[CH_AM] |
                 w_upd[CH_DM] | w_sp_upd | (w_upd[CH_E] & ~w_flt) | w_flt_pulse;

endmodule : sensor_filtro

// File: tb/tb_sensor_filtro.sv
// -----------------------------------------------------------------------------
// tb_sensor_filtro
// Directed bench for sensor_filtro with DB_CYCLES = 4. Inputs are driven and
// outputs sampled on the falling clock edge. Packed vector layout used below:
//   [7] RF  [6] TM  [5] SC  [4] E  [3] AM  [2] DM  [1:0] SP
// -----------------------------------------------------------------------------
module tb_sensor_filtro;

    logic       clk = 1'b0;
    logic       rst;
    logic       RF_raw, TM_raw, SC_raw, E_raw, AM_raw, DM_raw;
    logic [1:0] SP_raw;
    logic       RF, TM, SC, E, AM, DM;
    logic [1:0] SP;
    logic       CHG, FLT;

    int errors  = 0;
    int checks  = 0;
    int chg_cnt = 0;

    always #5 clk = ~clk;

    sensor_filtro #(
        .DB_CYCLES    (4),
        .STUCK_CYCLES (255)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .RF_raw (RF_raw),
        .TM_raw (TM_raw),
        .SC_raw (SC_raw),
        .E_raw  (E_raw),
        .AM_raw (AM_raw),
        .DM_raw (DM_raw),
        .SP_raw (SP_raw),
        .RF     (RF),
        .TM     (TM),
        .SC     (SC),
        .E      (E),
        .AM     (AM),
        .DM     (DM),
        .SP     (SP),
        .CHG    (CHG),
        .FLT    (FLT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {RF, TM, SC, E, AM, DM, SP};
    endfunction

    task automatic set_raw(input logic [7:0] v);
        {RF_raw, TM_raw, SC_raw, E_raw, AM_raw, DM_raw, SP_raw} = v;
    endtask

    // Advance n clock cycles, sampling after each falling edge and counting CHG.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (CHG === 1'b1) chg_cnt++;
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] raw;
        int         cyc;
        logic [7:0] exp_out;
        int         exp_chg;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Hand-computed vectors, applied back to back from an all-zero state.
        tbl[0]  = '{"settle_zero",    8'b0000_0000, 8, 8'b0000_0000, 0};
        tbl[1]  = '{"tm_rise_wait",   8'b0100_0000, 5, 8'b0000_0000, 0};
        tbl[2]  = '{"tm_rise_6",      8'b0100_0000, 1, 8'b0100_0000, 1};
        tbl[3]  = '{"tm_hold",        8'b0100_0000, 3, 8'b0100_0000, 0};
        tbl[4]  = '{"am_pulse3",      8'b0100_1000, 3, 8'b0100_0000, 0};
        tbl[5]  = '{"am_pulse_after", 8'b0100_0000, 8, 8'b0100_0000, 0};
        tbl[6]  = '{"sp_01_short",    8'b0100_0001, 2, 8'b0100_0000, 0};
        tbl[7]  = '{"sp_10_wait",     8'b0100_0010, 5, 8'b0100_0000, 0};
        tbl[8]  = '{"sp_10_land",     8'b0100_0010, 1, 8'b0100_0010, 1};
        tbl[9]  = '{"multi_change",   8'b1010_0110, 6, 8'b1010_0110, 1};
        tbl[10] = '{"multi_hold",     8'b1010_0110, 2, 8'b1010_0110, 0};
        tbl[11] = '{"e_pulse4",       8'b1011_0110, 4, 8'b1010_0110, 0};
        tbl[12] = '{"e_pulse4_land",  8'b1010_0110, 2, 8'b1011_0110, 1};
        tbl[13] = '{"e_fall",         8'b1010_0110, 6, 8'b1010_0110, 1};
        tbl[14] = '{"sp_glitch11",    8'b1010_0111, 1, 8'b1010_0110, 0};
    end

    initial begin
        // ---- Reset with all raw inputs high -------------------------------
        rst = 1'b1;
        set_raw(8'b1111_1111);
        run(2);
        check("reset_outs", {24'd0, outs()}, 32'h0);
        check("reset_chg",  {31'd0, CHG},    32'h0);
        check("reset_flt",  {31'd0, FLT},    32'h0);

        rst = 1'b0;
        chg_cnt = 0;
        run(5);
        check("release_5cyc_outs", {24'd0, outs()}, 32'h0);
        run(1);
        check("release_6cyc_outs", {24'd0, outs()}, 32'hFF);
        check("release_6cyc_chg",  {31'd0, CHG},    32'h1);
        run(1);
        check("release_chg_once",  chg_cnt,         32'd1);

        // Back to all-zero for the table.
        set_raw(8'b0000_0000);
        run(8);
        check("clear_outs", {24'd0, outs()}, 32'h0);

        // ---- Table-driven vectors -----------------------------------------
        for (int i = 0; i < 15; i++) begin
            set_raw(tbl[i].raw);
            chg_cnt = 0;
            run(tbl[i].cyc);
            check({tbl[i].name, "_out"}, {24'd0, outs()}, {24'd0, tbl[i].exp_out});
            check({tbl[i].name, "_chg"}, chg_cnt,         tbl[i].exp_chg);
        end
        // Finish the SP glitch: back to 10 and confirm nothing moves.
        set_raw(8'b1010_0110);
        chg_cnt = 0;
        run(8);
        check("sp_glitch_out", {24'd0, outs()}, 32'hA6);
        check("sp_glitch_chg", chg_cnt,         32'd0);
`ifndef SENSOR_STUCK_DETECT_EN
        check("flt_tied_low",  {31'd0, FLT},    32'h0);
`endif

        // ---- Reset mid-count discards partial AM count --------------------
        set_raw(8'b0000_0000);
        run(8);
        set_raw(8'b0000_1000);
        run(3);
        rst = 1'b1;
        run(1);
        check("midcount_reset_am", {31'd0, AM}, 32'h0);
        rst = 1'b0;
        run(5);
        check("midcount_5cyc_am",  {31'd0, AM}, 32'h0);
        run(1);
        check("midcount_6cyc_am",  {31'd0, AM}, 32'h1);
        check("midcount_6cyc_chg", {31'd0, CHG}, 32'h1);

        // ---- AM and DM together pass through unchanged ----------------------
        set_raw(8'b0000_1100);
        run(6);
        check("am_dm_both", {24'd0, outs()}, 32'h0C);

`ifdef SENSOR_STUCK_DETECT_EN
        // ---- Stuck TM with E high: fault at cycle 2+4+255 -------------------
        rst = 1'b1;
        set_raw(8'b0101_0000);
        run(2);
        rst = 1'b0;
        run(260);
        check("stuck_260_flt", {31'd0, FLT}, 32'h0);
        check("stuck_260_e",   {31'd0, E},   32'h1);
        run(1);
        check("stuck_261_flt", {31'd0, FLT}, 32'h1);
        check("stuck_261_e",   {31'd0, E},   32'h0);
        check("stuck_261_chg", {31'd0, CHG}, 32'h1);
        set_raw(8'b0001_0000);
        run(20);
        check("stuck_release_flt", {31'd0, FLT}, 32'h1);
        rst = 1'b1;
        run(1);
        check("stuck_rst_flt", {31'd0, FLT}, 32'h0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sensor_filtro
